lcd_rx_monitor: RTL and testbench

Receive-side monitor for the 8-bit serial-RGB LCD interface that the panel driver produces. It samples `lcd_dat`/`lcd_hsync`/`lcd_vsync`/`lcd_den` in the pixel-clock domain and reassembles byte triplets into 24-bit pixels with x/y coordinates. It measures active line and frame geometry, checks it against parameters, and raises sticky error flags. It is used in loopback on the board and as the checker in driver testbenches.

---
 rtl/lcd_rx_monitor.sv | 245 ++++++++++++++++++++++++
 tb/tb_lcd_rx_monitor.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rx_monitor.sv
// -----------------------------------------------------------------------------
// lcd_rx_monitor
//
// Receive-side monitor for the 8-bit serial-RGB LCD interface. Samples the
// LCD pins in the pixel-clock domain, rebuilds {R,G,B} pixels with x/y
// coordinates, measures line/frame geometry against H_ACTIVE/V_ACTIVE and
// raises sticky error flags.
//
// Ports
//   clk, resetn            pixel clock, asynchronous active-low reset
//   lcd_dat[7:0]           serial colour byte, order R, G, B
//   lcd_hsync, lcd_vsync   line / frame sync, active low
//   lcd_den                data enable, active high
//   err_clr                synchronous clear of err_line / err_frame
//   pix_valid              one-cycle strobe qualifying pix_rgb/pix_x/pix_y
//   pix_rgb[23:0]          reassembled {R,G,B}
//   pix_x, pix_y[9:0]      0-based coordinates, saturating at 1023
//   pix_sof                high with pix_valid for pixel (0,0)
//   frame_done             one-cycle pulse when a frame closes
//   meas_h, meas_v[9:0]    pixels in last good line / lines in last frame
//   frame_cnt[15:0]        closed-frame counter, wraps
//   err_line, err_frame    sticky error flags
//   locked                 two consecutive error-free frames seen
// -----------------------------------------------------------------------------
module lcd_rx_monitor #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  lcd_dat,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic        lcd_den,
    input  logic        err_clr,
    output logic        pix_valid,
    output logic [23:0] pix_rgb,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_sof,
    output logic        frame_done,
    output logic [9:0]  meas_h,
    output logic [9:0]  meas_v,
    output logic [15:0] frame_cnt,
    output logic        err_line,
    output logic        err_frame,
    output logic        locked
);

    localparam logic [9:0] H_EXP     = 10'(H_ACTIVE);
    localparam logic [9:0] V_EXP     = 10'(V_ACTIVE);
    localparam logic [9:0] COORD_MAX = 10'd1023;

    typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_e;

    typedef struct packed {
        logic [7:0] dat;
        logic       hsync;
        logic       vsync;
        logic       den;
    } lcd_smp_t;

    // ------------------------------------------------------------------
    // Input stage: one register on the pins, a second delayed copy for
    // edge detection. Edge flags are registered so that they line up with
    // the byte held in smp2_q.
    // ------------------------------------------------------------------
    lcd_smp_t smp1_q, smp2_q;
    logic     den_rise_q, den_fall_q, hs_fall_q, vs_fall_q;

    // NOTE: every register below is assigned with <= so all flops sample
    // the pre-edge values; blocking assignments here would chain stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            smp1_q     <= '0;
            smp2_q     <= '0;
            den_rise_q <= 1'b0;
            den_fall_q <= 1'b0;
            hs_fall_q  <= 1'b0;
            vs_fall_q  <= 1'b0;
        end else begin
            smp1_q     <= {lcd_dat, lcd_hsync, lcd_vsync, lcd_den};
            smp2_q     <= smp1_q;
            den_rise_q <=  smp1_q.den   & ~smp2_q.den;
            den_fall_q <= ~smp1_q.den   &  smp2_q.den;
            hs_fall_q  <= ~smp1_q.hsync &  smp2_q.hsync;
            vs_fall_q  <= ~smp1_q.vsync &  smp2_q.vsync;
        end
    end

    // ------------------------------------------------------------------
    // Core state
    // ------------------------------------------------------------------
    state_e      state_q;
    logic [1:0]  phase_q;
    logic [7:0]  r_q, g_q;
    logic [9:0]  x_q, y_q;
    logic        x_ovf_q, y_ovf_q;      // an increment was attempted at 1023
    logic [9:0]  line_len_q;            // pixel count of the last good line
    logic        prev_good_q;           // previous closed frame was clean
    logic        frame_err_q;           // an error event hit the current frame

    logic        pix_valid_q, pix_sof_q, frame_done_q;
    logic [23:0] pix_rgb_q;
    logic [9:0]  pix_x_q, pix_y_q, meas_h_q, meas_v_q;
    logic [15:0] frame_cnt_q;
    logic        err_line_q, err_frame_q, locked_q;

    // Event decode for the current cycle.
    logic close, line_end, abort, line_bad, hs_err;
    logic line_err_ev, frame_err_ev, err_ev, byte_en;

    assign close        = (state_q != IDLE) && vs_fall_q;
    assign abort        = close && (state_q == ACTIVE);
    assign line_end     = !close && (state_q == ACTIVE) && den_fall_q;
    assign line_bad     = line_end && ((phase_q != 2'd0) || (x_q != H_EXP) || x_ovf_q);
    assign hs_err       = (state_q != IDLE) && hs_fall_q && smp2_q.den;
    assign line_err_ev  = line_bad || hs_err || abort;
    assign frame_err_ev = close && ((y_q != V_EXP) || y_ovf_q);
    assign err_ev       = line_err_ev || frame_err_ev;
    // The den-rise cycle already carries the R byte in smp2_q.
    assign byte_en      = !close && (((state_q == BLANK) && den_rise_q) ||
                                     ((state_q == ACTIVE) && smp2_q.den));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            phase_q      <= 2'd0;
            r_q          <= '0;
            g_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            x_ovf_q      <= 1'b0;
            y_ovf_q      <= 1'b0;
            line_len_q   <= '0;
            prev_good_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_sof_q    <= 1'b0;
            frame_done_q <= 1'b0;
            pix_rgb_q    <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            meas_h_q     <= '0;
            meas_v_q     <= '0;
            frame_cnt_q  <= '0;
            err_line_q   <= 1'b0;
            err_frame_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            pix_valid_q  <= 1'b0;
            pix_sof_q    <= 1'b0;
            frame_done_q <= 1'b0;

            if (state_q == IDLE) begin
                // The frame in flight at reset is never measured.
                if (vs_fall_q) begin
                    state_q <= BLANK;
                    phase_q <= 2'd0;
                    x_q     <= '0;
                    y_q     <= '0;
                    x_ovf_q <= 1'b0;
                    y_ovf_q <= 1'b0;
                end
            end else if (close) begin
                // An aborted line never reached line_end, so y_q excludes it.
                state_q      <= BLANK;
                frame_done_q <= 1'b1;
                meas_v_q     <= y_q;
                meas_h_q     <= line_len_q;
                frame_cnt_q  <= frame_cnt_q + 16'd1;
                phase_q      <= 2'd0;
                x_q          <= '0;
                y_q          <= '0;
                x_ovf_q      <= 1'b0;
                y_ovf_q      <= 1'b0;
            end else begin
                if (line_end) begin
                    state_q <= BLANK;
                    phase_q <= 2'd0;
                    x_q     <= '0;
                    x_ovf_q <= 1'b0;
                    if (!line_bad) line_len_q <= x_q;
                    if (y_q == COORD_MAX) y_ovf_q <= 1'b1;
                    else                  y_q     <= y_q + 10'd1;
                end else if ((state_q == BLANK) && den_rise_q) begin
                    state_q <= ACTIVE;
                end

                if (byte_en) begin
                    unique case (phase_q)
                        2'd0: begin
                            r_q     <= smp2_q.dat;
                            phase_q <= 2'd1;
                        end
                        2'd1: begin
                            g_q     <= smp2_q.dat;
                            phase_q <= 2'd2;
                        end
                        default: begin
                            pix_valid_q <= 1'b1;
                            pix_rgb_q   <= {r_q, g_q, smp2_q.dat};
                            pix_x_q     <= x_q;
                            pix_y_q     <= y_q;
                            pix_sof_q   <= (x_q == '0) && (y_q == '0);
                            phase_q     <= 2'd0;
                            if (x_q == COORD_MAX) x_ovf_q <= 1'b1;
                            else                  x_q     <= x_q + 10'd1;
                        end
                    endcase
                end
            end

            // Sticky flags: a new error event beats a simultaneous clear.
            if (line_err_ev)  err_line_q  <= 1'b1;
            else if (err_clr) err_line_q  <= 1'b0;
            if (frame_err_ev) err_frame_q <= 1'b1;
            else if (err_clr) err_frame_q <= 1'b0;

            frame_err_q <= close ? 1'b0 : (frame_err_q | err_ev);

            if (err_ev) begin
                locked_q    <= 1'b0;
                prev_good_q <= 1'b0;
            end else if (close && !frame_err_q) begin
                if (prev_good_q) locked_q <= 1'b1;
                prev_good_q <= 1'b1;
            end
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_rgb    = pix_rgb_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_sof    = pix_sof_q;
    assign frame_done = frame_done_q;
    assign meas_h     = meas_h_q;
    assign meas_v     = meas_v_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_line   = err_line_q;
    assign err_frame  = err_frame_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// -----------------------------------------------------------------------------
// tb_lcd_rx_monitor
//
// Directed bench for lcd_rx_monitor with H_ACTIVE=4, V_ACTIVE=3. Inputs are
// driven on the falling clock edge; outputs are observed on the falling edge
// or 1 ns after the rising edge. Each line carries bytes 0x01, 0x02, ...
// -----------------------------------------------------------------------------
module tb_lcd_rx_monitor;

    localparam int H = 4;
    localparam int V = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  lcd_dat = 8'h00;
    logic        lcd_hsync = 1'b1;
    logic        lcd_vsync = 1'b1;
    logic        lcd_den = 1'b0;
    logic        err_clr = 1'b0;

    logic        pix_valid;
    logic [23:0] pix_rgb;
    logic [9:0]  pix_x, pix_y;
    logic        pix_sof;
    logic        frame_done;
    logic [9:0]  meas_h, meas_v;
    logic [15:0] frame_cnt;
    logic        err_line, err_frame, locked;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [23:0] rgb;
        logic [9:0]  x;
        logic [9:0]  y;
    } pix_t;

    pix_t pix_q[$];
    int   sof_cnt = 0;
    int   fd_cnt  = 0;

    lcd_rx_monitor #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .lcd_dat    (lcd_dat),
        .lcd_hsync  (lcd_hsync),
        .lcd_vsync  (lcd_vsync),
        .lcd_den    (lcd_den),
        .err_clr    (err_clr),
        .pix_valid  (pix_valid),
        .pix_rgb    (pix_rgb),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_sof    (pix_sof),
        .frame_done (frame_done),
        .meas_h     (meas_h),
        .meas_v     (meas_v),
        .frame_cnt  (frame_cnt),
        .err_line   (err_line),
        .err_frame  (err_frame),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // Collect pixels and frame pulses just after each rising edge.
    always @(posedge clk) begin
        pix_t p;
        #1;
        if (pix_valid === 1'b1) begin
            p.rgb = pix_rgb;
            p.x   = pix_x;
            p.y   = pix_y;
            pix_q.push_back(p);
            if (pix_sof === 1'b1) sof_cnt++;
        end
        if (frame_done === 1'b1) fd_cnt++;
    end

    function automatic logic [85:0] all_outs();
        return {pix_valid, pix_rgb, pix_x, pix_y, pix_sof, frame_done,
                meas_h, meas_v, frame_cnt, err_line, err_frame, locked};
    endfunction

    // One clock of stimulus, applied on the falling edge.
    task automatic drive(input logic [7:0] d, input logic hs, input logic vs,
                         input logic den, input logic clr);
        @(negedge clk);
        lcd_dat   = d;
        lcd_hsync = hs;
        lcd_vsync = vs;
        lcd_den   = den;
        err_clr   = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // n bytes with den high, then one den-low cycle carrying the hsync pulse.
    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) drive(8'(i + 1), 1'b1, 1'b1, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Returns two edges after vsync low is sampled: frame-close results visible.
    task automatic vsync_pulse();
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic clear_errors();
        drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== 86'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_clean_frames();
        logic [23:0] exp_rgb;
        idle(3);
        vsync_pulse();
        // First line by hand: third byte at edge t, pix_valid seen after t+2.
        for (int i = 0; i < 12; i++) begin
            drive(8'(i + 1), 1'b1, 1'b1, 1'b1, 1'b0);
            if (i == 4) begin
                n_checks++;
                if (pix_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL pix_latency_early: got %b expected 0", pix_valid);
                end
            end
            if (i == 5) begin
                n_checks++;
                if ({pix_valid, pix_sof, pix_x, pix_y, pix_rgb} !== {1'b1, 1'b1, 10'd0, 10'd0, 24'h010203}) begin
                    n_errors++;
                    $display("FAIL pix_latency: got v=%b sof=%b x=%0d y=%0d rgb=%h expected v=1 sof=1 x=0 y=0 rgb=010203",
                             pix_valid, pix_sof, pix_x, pix_y, pix_rgb);
                end
            end
        end
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        send_line(12);
        send_line(12);
        // Frame close timing: vsync low sampled at edge t.
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        n_checks++;
        if ({frame_done, frame_cnt} !== {1'b0, 16'd0}) begin
            n_errors++;
            $display("FAIL close_early: got done=%b cnt=%0d expected done=0 cnt=0", frame_done, frame_cnt);
        end
        idle(1);
        n_checks++;
        if ({frame_done, frame_cnt, meas_v, meas_h} !== {1'b1, 16'd1, 10'd3, 10'd4}) begin
            n_errors++;
            $display("FAIL close_t2: got done=%b cnt=%0d v=%0d h=%0d expected done=1 cnt=1 v=3 h=4",
                     frame_done, frame_cnt, meas_v, meas_h);
        end
        send_line(12);
        send_line(12);
        send_line(12);
        vsync_pulse();
        idle(2);
        n_checks++;
        if ({fd_cnt, frame_cnt, meas_h, meas_v} !== {32'd2, 16'd2, 10'd4, 10'd3}) begin
            n_errors++;
            $display("FAIL two_frames: got pulses=%0d cnt=%0d h=%0d v=%0d expected 2 2 4 3",
                     fd_cnt, frame_cnt, meas_h, meas_v);
        end
        n_checks++;
        if ({locked, err_line, err_frame} !== 3'b100) begin
            n_errors++;
            $display("FAIL locked_clean: got lock=%b el=%b ef=%b expected 1 0 0", locked, err_line, err_frame);
        end
        n_checks++;
        if (pix_q.size() != 24 || sof_cnt != 2) begin
            n_errors++;
            $display("FAIL pixel_count: got %0d pixels %0d sof expected 24 and 2", pix_q.size(), sof_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            exp_rgb = {8'(3 * k + 1), 8'(3 * k + 2), 8'(3 * k + 3)};
            n_checks++;
            if ({pix_q[k].rgb, pix_q[k].x, pix_q[k].y} !== {exp_rgb, 10'(k), 10'd0}) begin
                n_errors++;
                $display("FAIL pixel_%0d: got rgb=%h x=%0d y=%0d expected rgb=%h x=%0d y=0",
                         k, pix_q[k].rgb, pix_q[k].x, pix_q[k].y, exp_rgb, k);
            end
        end
        n_checks++;
        if ({pix_q[4].x, pix_q[4].y, pix_q[23].x, pix_q[23].y, pix_q[23].rgb} !==
            {10'd0, 10'd1, 10'd3, 10'd2, 24'h0A0B0C}) begin
            n_errors++;
            $display("FAIL pixel_coords: got p4=(%0d,%0d) p23=(%0d,%0d,%h) expected (0,1) (3,2,0a0b0c)",
                     pix_q[4].x, pix_q[4].y, pix_q[23].x, pix_q[23].y, pix_q[23].rgb);
        end
    endtask

    task automatic test_long_line();
        int p0;
        p0 = pix_q.size();
        for (int i = 0; i < 13; i++) drive(8'(i + 1), 1'b1, 1'b1, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        n_checks++;
        if (err_line !== 1'b0) begin
            n_errors++;
            $display("FAIL long_line_early: got %b expected 0", err_line);
        end
        idle(1);
        n_checks++;
        if ({err_line, locked} !== 2'b10 || pix_q.size() - p0 != 4) begin
            n_errors++;
            $display("FAIL long_line: got el=%b lock=%b pixels=%0d expected el=1 lock=0 pixels=4",
                     err_line, locked, pix_q.size() - p0);
        end
        clear_errors();
        n_checks++;
        if (err_line !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clr: got %b expected 0", err_line);
        end
    endtask

    task automatic test_short_frame();
        vsync_pulse();          // closes the frame holding the long line
        n_checks++;
        if ({err_frame, err_line, meas_v} !== {1'b1, 1'b0, 10'd1}) begin
            n_errors++;
            $display("FAIL one_line_frame: got ef=%b el=%b v=%0d expected 1 0 1", err_frame, err_line, meas_v);
        end
        clear_errors();
        n_checks++;
        if (err_frame !== 1'b0) begin
            n_errors++;
            $display("FAIL err_frame_clr: got %b expected 0", err_frame);
        end
        send_line(12);
        send_line(12);
        vsync_pulse();
        n_checks++;
        if ({err_frame, err_line, meas_v, meas_h, frame_cnt} !== {1'b1, 1'b0, 10'd2, 10'd4, 16'd4}) begin
            n_errors++;
            $display("FAIL short_frame: got ef=%b el=%b v=%0d h=%0d cnt=%0d expected 1 0 2 4 4",
                     err_frame, err_line, meas_v, meas_h, frame_cnt);
        end
    endtask

    task automatic test_vsync_abort();
        int p0;
        int f0;
        clear_errors();
        p0 = pix_q.size();
        f0 = fd_cnt;
        send_line(12);
        for (int i = 0; i < 4; i++) drive(8'(i + 1), 1'b1, 1'b1, 1'b1, 1'b0);
        drive(8'h05, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(8'h06, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        n_checks++;
        if (fd_cnt - f0 != 1 || {err_line, err_frame, meas_v, meas_h, frame_cnt} !==
            {1'b1, 1'b1, 10'd1, 10'd4, 16'd5}) begin
            n_errors++;
            $display("FAIL vsync_abort: got pulses=%0d el=%b ef=%b v=%0d h=%0d cnt=%0d expected 1 1 1 1 4 5",
                     fd_cnt - f0, err_line, err_frame, meas_v, meas_h, frame_cnt);
        end
        n_checks++;
        if (pix_q.size() - p0 != 5) begin
            n_errors++;
            $display("FAIL abort_pixels: got %0d expected 5", pix_q.size() - p0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        clear_errors();
        send_line(12);
        for (int i = 0; i < 5; i++) drive(8'(i + 1), 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== 86'd0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0", all_outs());
        end
        p0 = pix_q.size();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 5; i < 12; i++) drive(8'(i + 1), 1'b1, 1'b1, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        send_line(12);
        idle(2);
        n_checks++;
        if (pix_q.size() != p0) begin
            n_errors++;
            $display("FAIL reset_idle_pixels: got %0d expected 0", pix_q.size() - p0);
        end
        vsync_pulse();
        send_line(12);
        idle(2);
        n_checks++;
        if (pix_q.size() - p0 != 4 || frame_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_first_frame: got pixels=%0d cnt=%0d expected 4 0", pix_q.size() - p0, frame_cnt);
        end
        n_checks++;
        if ({pix_q[p0].rgb, pix_q[p0].x, pix_q[p0].y} !== {24'h010203, 10'd0, 10'd0}) begin
            n_errors++;
            $display("FAIL reset_first_pixel: got rgb=%h x=%0d y=%0d expected 010203 0 0",
                     pix_q[p0].rgb, pix_q[p0].x, pix_q[p0].y);
        end
    endtask

    task automatic test_clr_collision();
        send_line(9);                               // den low sampled at edge t
        idle(1);
        drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);       // err_clr high at edge t+2
        n_checks++;
        if (err_line !== 1'b0) begin
            n_errors++;
            $display("FAIL collision_pre: got %b expected 0", err_line);
        end
        idle(1);
        n_checks++;
        if (err_line !== 1'b1) begin
            n_errors++;
            $display("FAIL collision: got %b expected 1", err_line);
        end
        idle(1);
        n_checks++;
        if (err_line !== 1'b1) begin
            n_errors++;
            $display("FAIL collision_hold: got %b expected 1", err_line);
        end
    endtask

    task automatic test_hsync_in_line();
        int p0;
        clear_errors();
        p0 = pix_q.size();
        for (int i = 0; i < 12; i++) drive(8'(i + 1), (i == 6) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        n_checks++;
        if (err_line !== 1'b1 || pix_q.size() - p0 != 4) begin
            n_errors++;
            $display("FAIL hsync_in_line: got el=%b pixels=%0d expected 1 4", err_line, pix_q.size() - p0);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frames();
        test_long_line();
        test_short_frame();
        test_vsync_abort();
        test_reset_mid_frame();
        test_clr_collision();
        test_hsync_in_line();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
